// File: rtl/fibonacci_seq.sv
// Iterative Fibonacci/Lucas engine: one addition per cycle, exact overflow tracking.
// Optional saturation on overflow is enabled by defining FIBONACCI_SEQ_SAT_EN.
module fibonacci_seq #(
  parameter int DATA_W = 32,
  parameter int N_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_W-1:0]    in_data,
  input  logic              in_mode,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] SEED_FIB   = '0;
  localparam logic [DATA_W-1:0] SEED_LUCAS = DATA_W'(2);
  localparam logic [DATA_W-1:0] SEED_ONE   = DATA_W'(1);

  state_t            state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [N_W-1:0]    cnt;
  logic              ovf_a;
  logic              ovf_b;

  logic [DATA_W:0]   sum;
  logic              carry;
  logic [DATA_W-1:0] b_next;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[DATA_W];

  // Once b has overflowed it stays pinned at all-ones so the result saturates.
`ifdef FIBONACCI_SEQ_SAT_EN
  assign b_next = (carry | ovf_a | ovf_b) ? '1 : sum[DATA_W-1:0];
`else
  assign b_next = sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      ovf_a     <= 1'b0;
      ovf_b     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a        <= in_mode ? SEED_LUCAS : SEED_FIB;
            b        <= SEED_ONE;
            cnt      <= in_data;
            ovf_a    <= 1'b0;
            ovf_b    <= 1'b0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a     <= b;
            b     <= b_next;
            ovf_a <= ovf_b;
            ovf_b <= ovf_a | ovf_b | carry;
            cnt   <= cnt - 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_data  <= a;
            out_ovf   <= ovf_a;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Directed bench for fibonacci_seq (DATA_W=32, N_W=8), expected values hand-computed.
module tb_fibonacci_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_mode = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  fibonacci_seq #(.DATA_W(32), .N_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_request(input logic [7:0] n, input logic mode);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = n;
    in_mode  = mode;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_output("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_response(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
    check_output("resp_seen", out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] n, input logic mode,
                                input logic [31:0] exp_data, input logic exp_ovf, input int exp_lat);
    int lat;
    accept_request(n, mode);
    wait_response(lat);
    check_output({tag, "_data"}, out_data, exp_data);
    check_output({tag, "_ovf"}, out_ovf, exp_ovf);
    if (exp_lat >= 0) check_output({tag, "_lat"}, lat, exp_lat);
    consume();
    check_output({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] exp48;
`ifdef FIBONACCI_SEQ_SAT_EN
    exp48 = 32'd4294967295;
`else
    exp48 = 32'd512559680;
`endif

    repeat (3) tick();
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_ovf", out_ovf, 0);
    #2 rst = 1'b1;
    tick();
    check_output("post_rst_ready", in_ready, 1);

    apply_stimulus("fib10", 8'd10, 1'b0, 32'd55, 1'b0, 11);
    apply_stimulus("fib0", 8'd0, 1'b0, 32'd0, 1'b0, 1);
    apply_stimulus("luc0", 8'd0, 1'b1, 32'd2, 1'b0, 1);
    apply_stimulus("luc10", 8'd10, 1'b1, 32'd123, 1'b0, 11);
    apply_stimulus("fib1", 8'd1, 1'b0, 32'd1, 1'b0, 2);
    apply_stimulus("fib47", 8'd47, 1'b0, 32'd2971215073, 1'b0, 48);
    apply_stimulus("fib48", 8'd48, 1'b0, exp48, 1'b1, 49);

    // Back-pressure: response for n=5 must hold while n=3 waits at the input.
    accept_request(8'd5, 1'b0);
    wait_response(lat);
    check_output("bp_lat", lat, 6);
    in_valid = 1'b1;
    in_data  = 8'd3;
    in_mode  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("bp_data", out_data, 5);
      check_output("bp_valid", out_valid, 1);
      check_output("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp_turn_ready", in_ready, 1);
    check_output("bp_turn_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check_output("bp_next_taken", in_ready, 0);
    wait_response(lat);
    check_output("bp_next_lat", lat, 4);
    check_output("bp_next_data", out_data, 2);
    consume();

    // Reset in the middle of a long computation must discard it.
    accept_request(8'd200, 1'b0);
    repeat (50) tick();
    #1 rst = 1'b0;
    #1;
    check_output("abort_in_ready", in_ready, 0);
    check_output("abort_out_valid", out_valid, 0);
    tick();
    rst = 1'b1;
    tick();
    check_output("abort_rel_ready", in_ready, 1);
    repeat (5) tick();
    check_output("abort_no_stale", out_valid, 0);
    apply_stimulus("fib7", 8'd7, 1'b0, 32'd13, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fibonacci_seq.md
# fibonacci_seq

Parametrised iterative sequence engine, the next generation of the fixed 8-bit-in / 32-bit-out Fibonacci block. It accepts an index `n` and a mode on a valid/ready request channel. It computes the n-th Fibonacci or Lucas number at one addition per cycle with configurable result width, and reports exact overflow. The result is returned on a valid/ready response channel. It sits behind any requester that uses the standard req/payload/rsp handshake and is driven directly by an SvUTest top.

## Interface
Parameters:
- `DATA_W`, 32: result width; legal range ≥ 2.
- `N_W`, 8: index width.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: request valid.
- `in_data`  in  N_W: index n, unsigned.
- `in_mode`  in  1: 0 = Fibonacci (seeds 0,1); 1 = Lucas (seeds 2,1).
- `in_ready`  out  1: request accepted when `in_valid & in_ready`.
- `out_valid`  out  1: result valid.
- `out_data`  out  DATA_W: sequence value for index n.
- `out_ovf`  out  1: true value of element n did not fit in DATA_W bits.
- `out_ready`  in  1: response consumed when `out_valid & out_ready`.

## Operation
- Registers: `a`, `b` (DATA_W), `cnt` (N_W), `ovf_a`, `ovf_b`, 2-bit state.
- IDLE:
  - `in_ready`=1.
  - On request handshake: `a`←seed0, `b`←seed1, `cnt`←n, `ovf_a`=`ovf_b`←0, go to CALC.
  - `in_data` and `in_mode` are sampled only at the handshake.
- CALC, `in_ready`=0:
  - If `cnt`≠0, take one step: `a`←`b`; `b`←`a`+`b` (DATA_W+1-bit sum, carry c); `ovf_a`←`ovf_b`; `ovf_b`←`ovf_a`|`ovf_b`|c; `cnt`←`cnt`−1.
  - If `cnt`=0, go to OUT with no step.
- OUT:
  - `out_valid`=1, `out_data`=`a`, `out_ovf`=`ovf_a`.
  - All are held stable until `out_ready`.
  - On response handshake, go to IDLE.
- Overflow is exact. Overflow of the look-ahead value `b` alone does not flag the result: F(47) at DATA_W=32 returns `out_ovf`=0 even though F(48) overflowed internally.
- Without saturation (see Configuration), arithmetic wraps modulo 2^DATA_W.
- n=0 returns seed0 directly (0 or 2); n=1 returns 1 after one step.
- Reset mid-operation (any state) aborts the computation and returns to IDLE. No response is produced for the aborted request.

## Timing
- Reset values:
  - Outputs: `in_ready`=0 while `rst` is low, 1 in the first cycle after release; `out_valid`=0; `out_data`=0; `out_ovf`=0.
  - Internal: state=IDLE, all other registers 0.
- Latency: with the request accepted at edge E0, `out_valid` rises after edge E(n+1), i.e. n+1 cycles later.
- Throughput: one request in flight. Next `in_ready` is one cycle after the response handshake; there is no same-cycle turnaround.
- Back-pressure: holding `out_ready`=0 stalls indefinitely with no loss. `in_ready` stays 0 throughout the stall.
- No combinational path from `out_ready` or `in_valid` to any output. All outputs decode directly from registers.

## Configuration
- `FIBONACCI_SEQ_SAT_EN` defined:
  - On any step where c=1 or `ovf_a`|`ovf_b`=1, `b`←all-ones. Overflowed results therefore read 2^DATA_W−1.
  - `out_ovf` semantics are unchanged.
- Not defined: wrap-around arithmetic as above. Saturation logic is absent from the netlist.

## Test plan
- Reset, then request n=10, mode 0, DATA_W=32 → `out_data`=55, `out_ovf`=0, `out_valid` rises 11 cycles after accept.
- n=0 with mode 0, then n=0 with mode 1, then n=10 with mode 1 → 0, 2, 123 respectively, each with `out_ovf`=0; n=0 latency is 1 cycle.
- DATA_W=32, n=47 → 2971215073 with `out_ovf`=0. n=48 → `out_ovf`=1, `out_data`=512559680 without the macro or 4294967295 with it.
- Request n=5, hold `out_ready`=0 for 20 cycles while driving `in_valid`=1 with n=3:
  - `out_data`=5 stays stable throughout and `in_ready` stays 0.
  - After `out_ready`, n=3 is accepted one cycle later and returns 2.
- Assert `rst` low during CALC of n=200, then request n=7 → no stale response; first `out_data`=13.
